// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame constants and the
// oversample-divider helper used by the receive and transmit controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_FRAME_BITS = 10;

  // Truncating divide: a fractional remainder becomes a small baud error.
  function automatic int baud_div(input int clk_hz, input int baud, input int osr);
    return clk_hz / (baud * osr);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: a one-cycle pulse every DIV clocks, with a
// restart input so the phase can be re-aligned to a line edge.
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge sysclk) begin
    if (reset || restart) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizer, oversampling frame FSM, a small
// first-word-fall-through FIFO, sticky error flags and a registered irq.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int OSR    = 16,
  parameter int DEPTH  = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       irq
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OSR);
  localparam int TW  = $clog2(OSR);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OSR / 2 - 1);
  localparam int AW  = $clog2(DEPTH);

  logic sync1_reg, rxs_reg;
  logic tick, restart;

  rx_state_t   state_reg, state_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [2:0]  bitn_reg, bitn_next;
  logic [7:0]  shreg_reg, shreg_next;
  logic        push_reg, push_next;
  logic        fe_set;

  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]  mem_reg [DEPTH];
  logic        fifo_empty, fifo_full, do_push, do_pop, ovr_set;
  logic        frame_err_reg, overrun_reg, irq_reg;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      rxs_reg   <= sync1_reg;
    end
  end

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg <= IDLE;
      tcnt_reg  <= '0;
      bitn_reg  <= '0;
      shreg_reg <= '0;
      push_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
      bitn_reg  <= bitn_next;
      shreg_reg <= shreg_next;
      push_reg  <= push_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tcnt_next  = tcnt_reg;
    bitn_next  = bitn_reg;
    shreg_next = shreg_reg;
    push_next  = 1'b0;
    fe_set     = 1'b0;
    restart    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxs_reg) begin
          restart    = 1'b1;
          tcnt_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_reg == T_HALF) begin
            tcnt_next  = '0;
            bitn_next  = '0;
            state_next = rxs_reg ? IDLE : DATA;
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_reg == T_LAST) begin
            shreg_next = {rxs_reg, shreg_reg[7:1]};
            tcnt_next  = '0;
            bitn_next  = bitn_reg + 3'd1;
            if (bitn_reg == 3'd7) state_next = STOP;
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt_reg == T_LAST) begin
            // Low stop bit: drop the byte and wait out a held-low line.
            if (rxs_reg) begin
              push_next  = 1'b1;
              state_next = IDLE;
            end else begin
              fe_set     = 1'b1;
              state_next = BREAK;
            end
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
      end
      BREAK: begin
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = rd_en && !fifo_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_reg && (!fifo_full || do_pop);
  assign ovr_set = push_reg && fifo_full && !do_pop;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg[AW-1:0]] <= shreg_reg;
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      if (fe_set)       frame_err_reg <= 1'b1;
      else if (clr_err) frame_err_reg <= 1'b0;
      if (ovr_set)      overrun_reg <= 1'b1;
      else if (clr_err) overrun_reg <= 1'b0;
      irq_reg <= !fifo_empty || frame_err_reg || overrun_reg;
    end
  end

  assign rx_data   = mem_reg[rd_ptr_reg[AW-1:0]];
  assign rx_valid  = !fifo_empty;
  assign rx_full   = fifo_full;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign irq       = irq_reg;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive controller for the board UART. It oversamples the asynchronous `uart_rx` line, validates the start and stop bits, assembles bytes LSB-first and buffers them in a small first-word-fall-through FIFO. The CPU peripheral bus reads it through a pop strobe, status flags and an interrupt line. It replaces ad-hoc bit-clock shifting with a sequenced, error-checked receive path.

## Interface
- `CLK_HZ`, 100_000_000: sysclk frequency.
- `BAUD`, 9600: line rate.
- `OSR`, 16: oversample ticks per bit. Must be even.
- `DEPTH`, 4: FIFO entries. Must be a power of 2.
- `sysclk` in 1: the only clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `uart_rx` in 1: asynchronous serial input. Idles high.
- `rd_en` in 1: pops the FIFO head. Ignored when empty.
- `clr_err` in 1: clears `frame_err` and `overrun`.
- `rx_data` out 8: FIFO head. Combinational from storage. Valid only while `rx_valid` is high.
- `rx_valid` out 1: FIFO not empty.
- `rx_full` out 1: FIFO holds `DEPTH` entries.
- `frame_err` out 1: sticky. Set when a stop bit is sampled low.
- `overrun` out 1: sticky. Set when a byte is dropped because the FIFO is full.
- `irq` out 1: registered. Equals `rx_valid | frame_err | overrun`, delayed one cycle.

## Operation
- Input synchronizer: 2-FF chain on `uart_rx`, both stages reset to 1. All FSM decisions use the second stage, `rxs`.
- Tick generator:
  - `DIV = CLK_HZ/(BAUD*OSR)`, integer truncation. The counter width is `$clog2(DIV)`.
  - Emits a one-cycle `tick` every `DIV` cycles.
  - The FSM restarts it (count = 0) on start-bit detection, so sampling is phase-aligned to the falling edge.
- FSM states:
  - IDLE: when `rxs`=0, clear the tick counter and `tcnt`, then go to START.
  - START: counts ticks. At `tcnt`=OSR/2-1 (mid start bit):
    - `rxs`=0: go to DATA, with `tcnt`=0 and `bitn`=0.
    - `rxs`=1: glitch; return to IDLE and push nothing.
  - DATA: on each tick where `tcnt`=OSR-1, shift `rxs` into `shreg[7]`, shifting right (LSB arrives first), then `bitn`++. After `bitn`=7 is sampled, go to STOP.
  - STOP: at `tcnt`=OSR-1:
    - `rxs`=1: push `shreg` (see below), then go to IDLE.
    - `rxs`=0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- FIFO:
  - Pointers are `$clog2(DEPTH)+1` bits. Empty when the pointers are equal. Full when the MSBs differ and the rest are equal. Pointers wrap modulo 2·DEPTH.
  - A push while full is dropped and sets `overrun`, unless `rd_en` pops in the same cycle. In that case both the pop and the push happen and `overrun` is not set.
  - A push and pop in the same cycle while empty: the pop is ignored and the push succeeds.
- Error flags: if `clr_err` coincides with a new error event in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE.
  - Pointers 0, so `rx_valid`=0 and `rx_full`=0.
  - `rx_data`=8'h00, because storage is reset.
  - `frame_err`=0, `overrun`=0, `irq`=0.
  - Synchronizer stages = 1.
- A reset asserted mid-frame aborts the frame. No partial byte is pushed.
- Detection latency: the falling edge on the pin reaches `rxs` after 2 cycles.
- Push latency: the push occurs on the cycle after the stop-bit sample tick. `rx_valid` rises the following cycle, and `irq` one cycle after that.
- Pop: `rd_en` high at edge N. The new head appears on `rx_data` after edge N.
- The FSM advances only on `tick` cycles, except IDLE→START and BREAK→IDLE, which happen on any cycle.

## Structure
- Package `uart_pkg`:
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - Function `baud_div(clk_hz, baud, osr)`.
  - Constant `UART_FRAME_BITS = 10`.
- Sub-module `uart_tick_gen`:
  - Parameter: `DIV`.
  - Ports: `sysclk`, `reset`, `restart`, `tick`.
  - Shared with a future transmit controller.
- The FIFO is inline. It is too small to warrant its own module.

## Test plan
All scenarios use `CLK_HZ`=1_536_000, `BAUD`=9600, `OSR`=16. This gives `DIV`=10 and 160 cycles per bit.
- Send 0xA5, 8N1, no reads:
  - `rx_valid` rises within 1 bit time after the stop-bit midpoint.
  - `rx_data`=0xA5, `irq`=1, no error flags.
- Send 0x00, 0xFF, 0x3C, 0x81 back-to-back, then pulse `rd_en` 4 times: bytes read in order, then `rx_valid`=0.
- Send a 5-byte burst with no reads:
  - First 4 bytes retained, `rx_full`=1.
  - `overrun`=1, 5th byte discarded.
  - `clr_err` clears `overrun` while `rx_valid` stays 1.
- Send 0x55 with the stop bit forced low, then the line held low for 3 bit times, then 0x12:
  - `frame_err`=1, no push for 0x55.
  - 0x12 is received correctly after the line returns high.
- Drive a 40-cycle low glitch on an idle line: FSM returns to IDLE, no push, no flags.
- Assert `reset` for 1 cycle mid-DATA of 0x77, then send 0x9C:
  - All outputs are at their reset values after the reset edge.
  - Only 0x9C appears in the FIFO.
